// File: rtl/qam_pkg.sv
// Shared types and symbol mapping for the QAM demodulator and modulator sides.
package qam_pkg;

  localparam int unsigned DIBIT_W = 2;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hB4;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } seq_state_e;

  // 2-bit Gray to binary: 00->00, 01->01, 11->10, 10->11
  function automatic logic [DIBIT_W-1:0] gray_decode(input logic [DIBIT_W-1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/qam_demod_sequencer_if.sv
// Byte stream from the demodulator sequencer to its valid/ready consumer.
interface qam_demod_sequencer_if;
  import qam_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/qam_phase_gen.sv
// Carrier LUT phase counter and symbol sampling strobe for the demod sequencer.
module qam_phase_gen #(
  parameter int unsigned SPS          = 16,
  parameter int unsigned PHASE_W      = 4,
  parameter int unsigned SAMPLE_PHASE = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PHASE_W-1:0] phase_addr,
  output logic               sym_tick,
  output logic               sample_c
);

  // Capture edge: the same edge that raises sym_tick
  assign sample_c = en && (phase_addr == PHASE_W'(SAMPLE_PHASE));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_addr <= '0;
      sym_tick   <= 1'b0;
    end else if (en) begin
      phase_addr <= (phase_addr == PHASE_W'(SPS - 1)) ? '0 : phase_addr + PHASE_W'(1);
      sym_tick   <= sample_c;
    end else begin
      sym_tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/qam_demod_sequencer.sv
// QAM demod controller: LUT phase, sync hunt, symbol-to-byte packing, byte handshake.
// Define QAM_SEQ_GRAY_EN to Gray-decode each captured dibit before hunting and packing.
module qam_demod_sequencer
  import qam_pkg::*;
#(
  parameter int unsigned       SPS          = 16,
  parameter int unsigned       PHASE_W      = 4,
  parameter int unsigned       SAMPLE_PHASE = 15,
  parameter logic [BYTE_W-1:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int unsigned       FRAME_BYTES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIBIT_W-1:0]   data_demod,
  output logic [PHASE_W-1:0]   phase_addr,
  output logic                 sym_tick,
  qam_demod_sequencer_if.master byte_if,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  logic                       sample_c;
  logic [DIBIT_W-1:0]         dibit_c;
  logic [BYTE_W-1:0]          hunt_word_c;
  logic [BYTE_W-1:0]          byte_word_c;
  logic                       byte_done_c;
  logic                       frame_end_c;
  logic                       drop_c;

  seq_state_e                 state;
  logic [BYTE_W-DIBIT_W-1:0]  shreg;
  logic [BYTE_W-DIBIT_W-1:0]  pack;
  logic [1:0]                 dibit_cnt;
  logic [BYTE_W-1:0]          byte_cnt;

  qam_phase_gen #(
    .SPS          (SPS),
    .PHASE_W      (PHASE_W),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .phase_addr (phase_addr),
    .sym_tick   (sym_tick),
    .sample_c   (sample_c)
  );

`ifdef QAM_SEQ_GRAY_EN
  assign dibit_c = gray_decode(data_demod);
`else
  assign dibit_c = data_demod;
`endif

  // Only the three most recent symbols are stored; the fourth is the one arriving now
  assign hunt_word_c = {shreg, dibit_c};
  assign byte_word_c = {pack, dibit_c};
  assign byte_done_c = sample_c && (state == LOCKED) && (dibit_cnt == 2'd3);
  assign frame_end_c = byte_done_c && (byte_cnt == BYTE_W'(FRAME_BYTES - 1));
  assign drop_c      = byte_done_c && byte_if.byte_valid && !byte_if.byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= HUNT;
      shreg              <= '0;
      pack               <= '0;
      dibit_cnt          <= '0;
      byte_cnt           <= '0;
      locked             <= 1'b0;
      frame_done         <= 1'b0;
      overflow           <= 1'b0;
      byte_if.byte_data  <= '0;
      byte_if.byte_valid <= 1'b0;
    end else begin
      frame_done <= frame_end_c;

      if (sample_c) begin
        case (state)
          HUNT: begin
            shreg <= hunt_word_c[BYTE_W-DIBIT_W-1:0];
            if (hunt_word_c == SYNC_WORD) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              dibit_cnt <= '0;
              byte_cnt  <= '0;
            end
          end
          LOCKED: begin
            pack      <= byte_word_c[BYTE_W-DIBIT_W-1:0];
            dibit_cnt <= dibit_cnt + 2'd1;
            if (dibit_cnt == 2'd3) begin
              if (frame_end_c) begin
                state    <= HUNT;
                locked   <= 1'b0;
                shreg    <= '0;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + BYTE_W'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end

      // Output slot: a completing byte only lands if the slot is free or draining now
      if (byte_done_c && (!byte_if.byte_valid || byte_if.byte_ready)) begin
        byte_if.byte_data  <= byte_word_c;
        byte_if.byte_valid <= 1'b1;
      end else if (byte_if.byte_valid && byte_if.byte_ready) begin
        byte_if.byte_valid <= 1'b0;
      end

      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_demod_sequencer.sv
// Self-checking bench for qam_demod_sequencer against a symbol-level reference model.
module tb_qam_demod_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ovf_clr;
  logic [1:0] data_demod;
  logic [3:0] phase_addr;
  logic       sym_tick;
  logic       locked;
  logic       frame_done;
  logic       overflow;

  qam_demod_sequencer_if bif();

  qam_demod_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_demod (data_demod),
    .phase_addr (phase_addr),
    .sym_tick   (sym_tick),
    .byte_if    (bif),
    .locked     (locked),
    .frame_done (frame_done),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Reference model state, in plain integer arithmetic over logical symbols
  bit m_locked;
  bit m_fd;
  int m_win;
  int m_acc;
  int m_nsym;
  int m_nbytes;

  always @(posedge clk) begin
    if (!rst && bif.byte_valid && bif.byte_ready) rx_q.push_back(bif.byte_data);
  end

  // Line encoding the modulator would apply to a logical symbol
  function automatic logic [1:0] enc(input logic [1:0] s);
`ifdef QAM_SEQ_GRAY_EN
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      2'd2:    return 2'd3;
      default: return 2'd2;
    endcase
`else
    return s;
`endif
  endfunction

  task automatic m_reset();
    m_locked = 0; m_fd = 0; m_win = 0; m_acc = 0; m_nsym = 0; m_nbytes = 0;
  endtask

  task automatic m_step(input logic [1:0] s);
    m_fd = 0;
    if (!m_locked) begin
      m_win = (m_win * 4 + int'(s)) % 256;
      if (m_win == 'hB4) begin
        m_locked = 1; m_acc = 0; m_nsym = 0; m_nbytes = 0;
      end
    end else begin
      m_acc  = m_acc * 4 + int'(s);
      m_nsym = m_nsym + 1;
      if (m_nsym == 4) begin
        exp_q.push_back(8'(m_acc));
        m_acc = 0; m_nsym = 0; m_nbytes = m_nbytes + 1;
        if (m_nbytes == 8) begin
          m_fd = 1; m_locked = 0; m_win = 0;
        end
      end
    end
  endtask

  // Present one symbol, wait for its capture; rdy_cap>=0 sets byte_ready just before capture
  task automatic send_sym(input logic [1:0] s, input int rdy_cap);
    bit got = 0;
    data_demod = enc(s);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sym_tick) got = 1;
      else if (rdy_cap >= 0 && phase_addr == 4'd15) bif.byte_ready = rdy_cap[0];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sym_tick_timeout got none within 40 clks exp one");
      return;
    end
    m_step(s);
    checks++;
    if (locked !== 1'(m_locked)) begin
      errors++; $display("FAIL locked_per_sym got %b exp %b", locked, m_locked);
    end
    checks++;
    if (frame_done !== 1'(m_fd)) begin
      errors++; $display("FAIL frame_done_per_sym got %b exp %b", frame_done, m_fd);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int last_rdy);
    for (int j = 3; j >= 0; j--) send_sym(b[2*j+1 -: 2], (j == 0) ? last_rdy : -1);
  endtask

  task automatic send_sync();
    send_sym(2'd2, -1); send_sym(2'd3, -1); send_sym(2'd1, -1); send_sym(2'd0, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ovf_clr = 1'b0; data_demod = 2'd0; bif.byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({phase_addr, sym_tick, locked, frame_done, overflow} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %h exp 00", {phase_addr, sym_tick, locked, frame_done, overflow});
    end
    checks++;
    if ({bif.byte_data, bif.byte_valid} !== 9'h000) begin
      errors++; $display("FAIL reset_byte got %h exp 000", {bif.byte_data, bif.byte_valid});
    end
    rst = 1'b0;
    m_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (phase_addr !== 4'(k % 16)) begin
        errors++; $display("FAIL phase_count got %0d exp %0d", phase_addr, k % 16);
      end
      checks++;
      if (sym_tick !== 1'(((k - 1) % 16) == 15)) begin
        errors++; $display("FAIL sym_tick_timing got %b exp %b at k=%0d", sym_tick, ((k - 1) % 16) == 15, k);
      end
    end
  endtask

  task automatic test_sync_frame();
    rx_q.delete(); exp_q.delete();
    send_sync();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL sync_lock got %b exp 1", locked); end
    for (int b = 0; b < 8; b++) send_byte(8'(b), -1);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 8) begin errors++; $display("FAIL frame_count got %0d exp 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL frame_byte got %h exp %h", rx_q[i], 8'(i)); end
    end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL frame_unlock got %b exp 0", locked); end
  endtask

  task automatic test_false_sync();
    send_sym(2'd2, -1); send_sym(2'd3, -1); send_sym(2'd1, -1); send_sym(2'd1, -1);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL false_sync got %b exp 0", locked); end
    send_sym(2'd2, -1); send_sym(2'd3, -1); send_sym(2'd1, -1);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL partial_sync got %b exp 0", locked); end
    send_sym(2'd0, -1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL slide_sync got %b exp 1", locked); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_sync();
    bif.byte_ready = 1'b0;
    send_byte(8'hA5, -1);
    checks++;
    if ({bif.byte_valid, bif.byte_data, overflow} !== {1'b1, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL bp_first got v%b d%h o%b exp v1 dA5 o0", bif.byte_valid, bif.byte_data, overflow);
    end
    send_byte(8'h3C, -1);
    checks++;
    if ({bif.byte_valid, bif.byte_data, overflow} !== {1'b1, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL bp_drop got v%b d%h o%b exp v1 dA5 o1", bif.byte_valid, bif.byte_data, overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    rx_q.delete();
    bif.byte_ready = 1'b1;
    @(negedge clk);
    bif.byte_ready = 1'b0;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || bif.byte_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got n%0d v%b exp n1 A5 v0", rx_q.size(), bif.byte_valid);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    send_byte(8'h96, -1);
    checks++;
    if ({bif.byte_valid, bif.byte_data} !== {1'b1, 8'h96}) begin
      errors++; $display("FAIL b2b_first got v%b d%h exp v1 d96", bif.byte_valid, bif.byte_data);
    end
    send_byte(8'h5A, 1);
    checks++;
    if ({bif.byte_valid, bif.byte_data, overflow} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL b2b_swap got v%b d%h o%b exp v1 d5A o0", bif.byte_valid, bif.byte_data, overflow);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
      errors++; $display("FAIL b2b_accept got n%0d exp 1 byte 96", rx_q.size());
    end
    @(negedge clk);
    checks++;
    if (rx_q.size() != 2 || rx_q[1] !== 8'h5A || bif.byte_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got n%0d v%b exp n2 5A v0", rx_q.size(), bif.byte_valid);
    end
  endtask

  task automatic test_en_gap_reset();
    logic [3:0] hold;
    int bad_phase = 0;
    int bad_tick = 0;
    rx_q.delete();
    bif.byte_ready = 1'b1;
    send_sym(2'd3, -1); send_sym(2'd0, -1);
    en = 1'b0;
    @(negedge clk);
    hold = phase_addr;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (phase_addr !== hold) bad_phase++;
      if (sym_tick !== 1'b0) bad_tick++;
    end
    checks++;
    if (bad_phase != 0) begin errors++; $display("FAIL en_gap_phase got %0d moves exp 0", bad_phase); end
    checks++;
    if (bad_tick != 0) begin errors++; $display("FAIL en_gap_tick got %0d ticks exp 0", bad_tick); end
    en = 1'b1;
    send_sym(2'd0, -1); send_sym(2'd3, -1);
    @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) begin
      errors++; $display("FAIL en_gap_byte got n%0d exp 1 byte C3", rx_q.size());
    end
    bif.byte_ready = 1'b0;
    send_byte(8'h7E, -1);
    send_sym(2'd2, -1);
    checks++;
    if ({locked, bif.byte_valid} !== 2'b11) begin
      errors++; $display("FAIL pre_reset got l%b v%b exp l1 v1", locked, bif.byte_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    checks++;
    if ({locked, bif.byte_valid, frame_done, overflow, phase_addr} !== 8'h00) begin
      errors++; $display("FAIL mid_reset got l%b v%b f%b o%b p%0d exp all 0", locked, bif.byte_valid, frame_done, overflow, phase_addr);
    end
  endtask

  task automatic test_random_frames();
    do_reset();
    bif.byte_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int junk = int'($urandom_range(0, 6));
      for (int i = 0; i < junk; i++) send_sym(2'($urandom), -1);
      send_sync();
      for (int i = 0; i < 32; i++) send_sym(2'($urandom), -1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d] got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sync_frame();
    test_false_sync();
    test_backpressure();
    test_back_to_back();
    test_en_gap_reset();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
